// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - framebuffer RAM arbiter between VGA display fetch and one pixel writer
// One fixed read slot per 8-pixel group while visible; every other cycle is granted to the writer.
module vga_fb_arbiter #(
  parameter int H_WORDS  = 80,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525,
  parameter int AW       = 16,
  parameter int DW       = 16
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          hd,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ack,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] pix_word,
  output logic          pix_vld,
  output logic          frame_start,
  output logic [9:0]    line
);

  typedef enum logic [1:0] {HBLANK, ACTIVE, VBLANK} state_t;

  state_t        state, state_nxt;
  logic          hd_q;
  logic          synced;
  logic [2:0]    phase;
  logic [6:0]    grp;
  logic          rd_q;

  logic          line_start, line_end, wrap, v_act;
  logic          act_cycle, read_slot;
  logic [2:0]    phase_eff;
  logic [6:0]    grp_eff;
  logic [AW-1:0] rd_addr;

  // A line end only counts once a line start has been seen since reset, so a
  // reset released mid-line or during blanking restarts cleanly at line 0.
  assign line_start = ~hd & hd_q;
  assign line_end   = hd & ~hd_q & synced;
  assign wrap       = line_end && (line == 10'(V_TOTAL - 1));
  assign v_act      = line < 10'(V_ACTIVE);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state <= HBLANK;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HBLANK: begin
        if (line_start && v_act)  state_nxt = ACTIVE;
        else if (!v_act && !wrap) state_nxt = VBLANK;
      end
      ACTIVE:  if (line_end) state_nxt = HBLANK;
      VBLANK:  if (wrap)     state_nxt = HBLANK;
      default: state_nxt = HBLANK;
    endcase
  end

  always_comb begin
    act_cycle = (state == ACTIVE) || (state == HBLANK && line_start && v_act);
    phase_eff = line_start ? 3'd0 : phase;
    grp_eff   = line_start ? 7'd0 : grp;
    read_slot = act_cycle && (phase_eff == 3'd0) && (grp_eff < 7'(H_WORDS));
    // Constant multiply by the line pitch reduces to a shift-add.
    rd_addr   = AW'(32'(line) * 32'(H_WORDS) + 32'(grp_eff));
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      hd_q        <= 1'b0;
      synced      <= 1'b0;
      line        <= '0;
      frame_start <= 1'b0;
      phase       <= '0;
      grp         <= '0;
    end else begin
      hd_q        <= hd;
      synced      <= synced | line_start;
      frame_start <= wrap;
      if (line_end) line <= wrap ? 10'd0 : line + 10'd1;
      if (act_cycle) begin
        phase <= phase_eff + 3'd1;
        if (phase_eff == 3'd7 && grp_eff < 7'(H_WORDS)) grp <= grp_eff + 7'd1;
        else                                            grp <= grp_eff;
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      wr_ack    <= 1'b0;
      rd_q      <= 1'b0;
      pix_word  <= '0;
      pix_vld   <= 1'b0;
    end else begin
      rd_q    <= read_slot;
      pix_vld <= rd_q;
      if (rd_q) pix_word <= mem_rdata;
      if (read_slot) begin
        mem_we   <= 1'b0;
        mem_addr <= rd_addr;
        wr_ack   <= 1'b0;
      end else if (wr_req) begin
        mem_we    <= 1'b1;
        mem_addr  <= wr_addr;
        mem_wdata <= wr_data;
        wr_ack    <= 1'b1;
      end else begin
        mem_we <= 1'b0;
        wr_ack <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - bench for vga_fb_arbiter
// Expectations come from a position-in-line model: reads at every 8th visible pixel of active lines.
module tb_vga_fb_arbiter;
  localparam int HW = 80;
  localparam int VA = 480;
  localparam int VT = 525;

  logic        clk = 1'b0;
  logic        clr_n, hd, wr_req;
  logic [15:0] wr_addr, wr_data, mem_addr, mem_wdata, mem_rdata, pix_word;
  logic        wr_ack, mem_we, pix_vld, frame_start;
  logic [9:0]  line;

  always #5 clk = ~clk;
  assign mem_rdata = mem_addr ^ 16'h5A3C;

  vga_fb_arbiter dut (
    .clk(clk), .clr_n(clr_n), .hd(hd), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ack(wr_ack), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .pix_word(pix_word),
    .pix_vld(pix_vld), .frame_start(frame_start), .line(line)
  );

  int n_cmp = 0, n_err = 0;
  int m_line, m_k;
  bit m_synced, m_act, m_prev_hd;
  logic [15:0] e_addr, e_wdata, e_word;
  logic e_we, e_ack, e_vld, e_fs;
  bit p_rd;
  logic [15:0] p_raddr;
  int wmode;
  bit w_pend;
  logic [15:0] w_addr, w_data;
  int n_pix, n_ack, n_fs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("wr_ack", 32'(wr_ack), 32'(e_ack));
    chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
    chk("pix_vld", 32'(pix_vld), 32'(e_vld));
    chk("pix_word", 32'(pix_word), 32'(e_word));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    chk("line", 32'(line), 32'(m_line));
  endtask

  task automatic model_reset();
    m_line = 0; m_k = 0; m_synced = 0; m_act = 0; m_prev_hd = 0;
    e_addr = 0; e_wdata = 0; e_word = 0; e_we = 0; e_ack = 0; e_vld = 0; e_fs = 0;
    p_rd = 0; p_raddr = 0;
  endtask

  task automatic cycle(input logic hv);
    bit st, en, rd, gr, l3;
    logic [15:0] ra;
    if (!w_pend && (wmode == 1 || (wmode == 2 && $urandom_range(0, 2) == 0))) begin
      w_pend = 1;
      w_addr = (wmode == 1) ? w_addr + 16'd1 : 16'($urandom);
      w_data = 16'($urandom);
    end
    hd = hv; wr_req = w_pend; wr_addr = w_addr; wr_data = w_data;
    st = m_prev_hd && !hv;
    en = !m_prev_hd && hv && m_synced;
    if (st) begin m_synced = 1; m_k = 0; m_act = (m_line < VA); end
    rd = m_act && (m_k % 8 == 0) && (m_k / 8 < HW);
    ra = 16'(m_line * HW + m_k / 8);
    l3 = rd && m_line == 3 && m_k == 40;
    gr = w_pend && !rd;
    e_vld = p_rd;
    if (p_rd) e_word = p_raddr ^ 16'h5A3C;
    p_rd = rd; p_raddr = ra;
    e_we = gr; e_ack = gr;
    if (rd) e_addr = ra;
    else if (gr) begin e_addr = w_addr; e_wdata = w_data; end
    e_fs = 0;
    if (en) begin
      m_act = 0;
      if (m_line == VT - 1) begin m_line = 0; e_fs = 1; end
      else m_line++;
    end
    m_prev_hd = hv;
    if (m_act) m_k++;
    @(posedge clk); #1;
    check_all();
    if (l3) chk("l3g5_addr", 32'(mem_addr), 32'd245);
    if (pix_vld) n_pix++;
    if (wr_ack) n_ack++;
    if (frame_start) n_fs++;
    if (gr) w_pend = 0;
  endtask

  task automatic run_line(input int vis, input int blank);
    for (int i = 0; i < vis; i++) cycle(1'b0);
    for (int i = 0; i < blank; i++) cycle(1'b1);
  endtask

  initial begin
    bit vb;
    int a, p, vb_cyc, vb_ack, vb_pix;
    clr_n = 0; hd = 1; wr_req = 0; wr_addr = 0; wr_data = 0;
    w_pend = 0; w_addr = 0; w_data = 0; wmode = 0;
    model_reset();
    #2 check_all();
    @(posedge clk); @(posedge clk); #1 clr_n = 1;
    for (int i = 0; i < 5; i++) cycle(1'b1);

    // idle writer: line 0 fetches 80 words
    n_pix = 0;
    run_line(640, 161);
    chk("l0_pix_count", 32'(n_pix), 32'd80);
    wmode = 2;
    for (int l = 0; l < 3; l++) run_line(640, 161);

    // continuous writer over a visible line: 7 of 8 cycles granted
    wmode = 1; n_ack = 0;
    for (int i = 0; i < 640; i++) cycle(1'b0);
    chk("act_ack_7of8", 32'(n_ack), 32'd560);
    for (int i = 0; i < 161; i++) cycle(1'b1);

    // short lines through the rest of the frame and the wrap
    n_fs = 0; vb_cyc = 0; vb_ack = 0; vb_pix = 0;
    do begin
      vb = (m_line >= VA); a = n_ack; p = n_pix;
      run_line(20, 8);
      if (vb) begin vb_cyc += 28; vb_ack += n_ack - a; vb_pix += n_pix - p; end
    end while (m_line != 0);
    chk("frame_start_count", 32'(n_fs), 32'd1);
    chk("vblank_acks", 32'(vb_ack), 32'(vb_cyc));
    chk("vblank_reads", 32'(vb_pix), 32'd0);

    // overlong visible line: reads stop at 80
    wmode = 2; n_pix = 0;
    run_line(700, 161);
    chk("long_pix_count", 32'(n_pix), 32'd80);

    // asynchronous reset at group 40 of line 100
    while (m_line != 100) run_line(20, 8);
    for (int i = 0; i < 320; i++) cycle(1'b0);
    #2 clr_n = 0;
    model_reset();
    #1 check_all();
    @(posedge clk); #1 clr_n = 1;
    for (int i = 0; i < 300; i++) cycle(1'b0);
    for (int i = 0; i < 161; i++) cycle(1'b1);
    chk("rst_line_zero", 32'(line), 32'd0);
    cycle(1'b0);
    chk("rst_first_rd_addr", 32'(mem_addr), 32'd0);
    chk("rst_first_rd_we", 32'(mem_we), 32'd0);
    for (int i = 0; i < 639; i++) cycle(1'b0);
    for (int i = 0; i < 161; i++) cycle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Shares the single-port framebuffer RAM between the VGA display fetch path and one pixel writer (drawing engine or CPU bridge). It tracks line and frame position from the horizontal blanking signal `hd`. During visible pixels it reserves one fixed read slot per 8-pixel group for display fetch; every other cycle belongs to the writer. It sits between the horizontal counter, the framebuffer RAM and the pixel shifter.

## Interface
- `H_WORDS`, 80: framebuffer words per visible line (8 pixels per word).
- `V_ACTIVE`, 480: visible lines per frame.
- `V_TOTAL`, 525: total lines per frame.
- `AW`, 16: RAM address width.
- `DW`, 16: RAM data width.

Ports:
- `clk` in 1: pixel clock.
- `clr_n` in 1: reset, asynchronous, active-low.
- `hd` in 1: horizontal blanking from the horizontal counter (0 = visible pixel, 1 = blanking).
- `wr_req` in 1: writer request, level.
- `wr_addr` in AW: write address.
- `wr_data` in DW: write data.
- `wr_ack` out 1: one-cycle acknowledge; the write was issued to RAM.
- `mem_addr` out AW: RAM address, registered.
- `mem_we` out 1: RAM write enable, registered.
- `mem_wdata` out DW: RAM write data, registered.
- `mem_rdata` in DW: RAM read data, valid 1 cycle after a read is issued.
- `pix_word` out DW: fetched display word.
- `pix_vld` out 1: one-cycle strobe; `pix_word` is new.
- `frame_start` out 1: one-cycle pulse when the line counter wraps to 0.
- `line` out 10: current line number.

## Operation
- `hd_q` is the registered copy of `hd`.
  - Line start: `hd=0`, `hd_q=1`.
  - Line end: `hd=1`, `hd_q=0`.
- Line counter:
  - Increments at each line end, wrapping from `V_TOTAL-1` to 0.
  - On wrap, `frame_start` is asserted for the following cycle.
  - Vertical active means `line < V_ACTIVE`.
- State machine:
  - HBLANK: reset state; `hd=1` or vertical blank.
  - ACTIVE: from HBLANK on a line start when vertically active. Back to HBLANK on a line end.
  - VBLANK: from HBLANK on a line end that makes `line == V_ACTIVE`. Back to HBLANK on wrap to line 0.
- ACTIVE counters:
  - `phase` is 3 bits; `grp` is 7 bits.
  - Both are forced to 0 in the line-start cycle.
  - `phase` increments every cycle.
  - `grp` increments when `phase == 7` and saturates at `H_WORDS`.
- Read slot: state ACTIVE (including the line-start cycle) with `phase == 0` and `grp < H_WORDS`.
  - At that edge: `mem_we <= 0`, `mem_addr <= line*H_WORDS + grp` (shift-add, truncated to AW).
  - The writer is not granted in a read-slot cycle.
- Write grant: any cycle that is not a read slot, with `wr_req=1`.
  - At that edge: `mem_we <= 1`, `mem_addr <= wr_addr`, `mem_wdata <= wr_data`, `wr_ack <= 1`.
  - Otherwise `mem_we <= 0` and `wr_ack <= 0`; `mem_addr` and `mem_wdata` hold.
- Writer handshake:
  - The writer holds `wr_addr` and `wr_data` stable while `wr_req=1` and `wr_ack=0`.
  - `wr_req` sampled during a cycle with `wr_ack=1` is a new transaction, so back-to-back writes are allowed.
- Reads beyond `H_WORDS` in a long line are suppressed; no address wraps into the next line.

## Timing
- Reset values: all outputs 0, `line` 0, state HBLANK, `hd_q` 0, `phase` and `grp` 0. The asynchronous reset may assert mid-line.
  - After release, no read is issued until an observed `hd` 1→0 transition.
- Display read latency:
  - Read issued at edge E (`mem_addr` valid after E).
  - `mem_rdata` is registered into `pix_word` at edge E+1.
  - `pix_vld=1` for the cycle after E+1, i.e. two cycles after the read-slot edge.
- Worst-case writer wait: 1 cycle in ACTIVE. The writer gets 7 of every 8 ACTIVE cycles and all HBLANK/VBLANK cycles.
- Simultaneous line end and wrap: the line counter goes to 0, `frame_start` pulses, and the state goes to HBLANK in the same edge.
- `wr_req` arriving in a read-slot cycle: granted at the next edge that is not a read slot.

## Test plan
- Reset with `hd` toggling 640 low / 161 high, no writer → line 0 produces reads at addresses 0..79. Reads are 8 cycles apart, the first in the line-start cycle. `pix_vld` appears 2 cycles after each read.
- Continuous `wr_req` during ACTIVE (incrementing `wr_addr`) → `wr_ack` is high 7 of every 8 cycles. It is low exactly in read-slot cycles, and no write address is skipped.
- Run 525 lines → `frame_start` is a single pulse at the wrap. Lines 480..524 produce no reads, and the writer is granted every cycle there.
- Line 3, group 5 → read address 245.
- `hd` held low for 700 cycles → exactly 80 reads, none at address ≥ `line*80+80`.
- `clr_n` asserted at group 40 of line 100 → outputs are 0 immediately. After release, `line=0`, and the first read is address 0 after the next `hd` falling edge.
